// File: rtl/axi_lite_audio_regs_pkg.sv
// Shared constants and write-channel state encoding for the AXI-Lite audio register bank.
package axi_audio_pkg;

  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam int         ADDR_LSB  = 2;
  localparam int         NUM_REGS  = 4;

  localparam logic [1:0] REG_CTRL = 2'd0;
  localparam logic [1:0] REG_VOL  = 2'd1;
  localparam logic [1:0] REG_MIX  = 2'd2;
  localparam logic [1:0] REG_AUX  = 2'd3;

  typedef enum logic [1:0] {
    WR_IDLE,
    WR_ADDR,
    WR_DATA,
    WR_RESP
  } wr_state_t;

endpackage

// File: rtl/axi_lite_audio_regs.sv
// AXI4-Lite responder with four read/write control registers for the audio mixer,
// plus a one-cycle update strobe per register.
//
// state   | meaning
// WR_IDLE | nothing held, AW and W both accepted
// WR_ADDR | address held, waiting for write data
// WR_DATA | data/strobe held, waiting for write address
// WR_RESP | write committed, BVALID high until BREADY
module axi_lite_audio_regs
  import axi_audio_pkg::*;
#(
  parameter int          C_S_AXI_DATA_WIDTH = 32,
  parameter int          C_S_AXI_ADDR_WIDTH = 4,
  parameter logic [31:0] RESET_VAL          = 32'h0000_0000
) (
  input  logic                                ACLK,
  input  logic                                ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]       S_AXI_AWADDR,
  input  logic [2:0]                          S_AXI_AWPROT,
  input  logic                                S_AXI_AWVALID,
  output logic                                S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]       S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]     S_AXI_WSTRB,
  input  logic                                S_AXI_WVALID,
  output logic                                S_AXI_WREADY,
  output logic [1:0]                          S_AXI_BRESP,
  output logic                                S_AXI_BVALID,
  input  logic                                S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]       S_AXI_ARADDR,
  input  logic [2:0]                          S_AXI_ARPROT,
  input  logic                                S_AXI_ARVALID,
  output logic                                S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]       S_AXI_RDATA,
  output logic [1:0]                          S_AXI_RRESP,
  output logic                                S_AXI_RVALID,
  input  logic                                S_AXI_RREADY,
  output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] ctrl_regs,
  output logic [NUM_REGS-1:0]                 reg_wr_pulse
);

  localparam int DW    = C_S_AXI_DATA_WIDTH;
  localparam int NB    = DW / 8;
  localparam int IDX_W = $clog2(NUM_REGS);

  wr_state_t        wr_state;
  logic             rst_done;
  logic [IDX_W-1:0] aw_idx_q;
  logic [DW-1:0]    w_data_q;
  logic [NB-1:0]    w_strb_q;
  logic [DW-1:0]    regs [NUM_REGS];

  logic             aw_hs, w_hs, ar_hs, commit;
  logic [IDX_W-1:0] wr_idx, rd_idx;
  logic [DW-1:0]    wr_data, wr_merged;
  logic [NB-1:0]    wr_strb;
  logic             unused_ok;

  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR, S_AXI_ARADDR};

  // rst_done keeps all READYs low until the first clock edge after reset release.
  assign S_AXI_AWREADY = rst_done && !S_AXI_BVALID &&
                         (wr_state == WR_IDLE || wr_state == WR_DATA);
  assign S_AXI_WREADY  = rst_done && !S_AXI_BVALID &&
                         (wr_state == WR_IDLE || wr_state == WR_ADDR);
  assign S_AXI_ARREADY = rst_done && !S_AXI_RVALID;
  assign S_AXI_BRESP   = RESP_OKAY;
  assign S_AXI_RRESP   = RESP_OKAY;

  assign aw_hs  = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_hs   = S_AXI_WVALID && S_AXI_WREADY;
  assign ar_hs  = S_AXI_ARVALID && S_AXI_ARREADY;
  assign commit = (aw_hs || wr_state == WR_ADDR) && (w_hs || wr_state == WR_DATA);

  assign wr_idx  = (wr_state == WR_ADDR) ? aw_idx_q : S_AXI_AWADDR[ADDR_LSB +: IDX_W];
  assign wr_data = (wr_state == WR_DATA) ? w_data_q : S_AXI_WDATA;
  assign wr_strb = (wr_state == WR_DATA) ? w_strb_q : S_AXI_WSTRB;
  assign rd_idx  = S_AXI_ARADDR[ADDR_LSB +: IDX_W];

  for (genvar g = 0; g < NB; g++) begin : g_lane
    assign wr_merged[8*g +: 8] = wr_strb[g] ? wr_data[8*g +: 8] : regs[wr_idx][8*g +: 8];
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      wr_state     <= WR_IDLE;
      rst_done     <= 1'b0;
      S_AXI_BVALID <= 1'b0;
      reg_wr_pulse <= '0;
      aw_idx_q     <= '0;
      w_data_q     <= '0;
      w_strb_q     <= '0;
    end else begin
      rst_done     <= 1'b1;
      reg_wr_pulse <= '0;
      if (aw_hs) aw_idx_q <= S_AXI_AWADDR[ADDR_LSB +: IDX_W];
      if (w_hs) begin
        w_data_q <= S_AXI_WDATA;
        w_strb_q <= S_AXI_WSTRB;
      end
      if (commit) begin
        wr_state             <= WR_RESP;
        S_AXI_BVALID         <= 1'b1;
        reg_wr_pulse[wr_idx] <= 1'b1;
      end else begin
        case (wr_state)
          WR_IDLE: begin
            if (aw_hs)     wr_state <= WR_ADDR;
            else if (w_hs) wr_state <= WR_DATA;
          end
          WR_RESP: begin
            if (S_AXI_BREADY) begin
              wr_state     <= WR_IDLE;
              S_AXI_BVALID <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= RESET_VAL;
    end else if (commit) begin
      regs[wr_idx] <= wr_merged;
    end
  end

  // A read accepted on a commit edge samples regs before the nonblocking update lands.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      S_AXI_RVALID <= 1'b0;
      S_AXI_RDATA  <= '0;
    end else if (ar_hs) begin
      S_AXI_RVALID <= 1'b1;
      S_AXI_RDATA  <= regs[rd_idx];
    end else if (S_AXI_RVALID && S_AXI_RREADY) begin
      S_AXI_RVALID <= 1'b0;
    end
  end

  always_comb begin
    ctrl_regs = '0;
    for (int i = 0; i < NUM_REGS; i++) ctrl_regs[DW*i +: DW] = regs[i];
  end

endmodule

// File: tb/tb_axi_lite_audio_regs.sv
// Directed bench for axi_lite_audio_regs: stimulus pushes expected B/R responses into queues,
// a negedge monitor pops and compares them on each handshake.
module tb_axi_lite_audio_regs;

  logic         tb_ACLK = 1'b0;
  logic         ARESETN;
  logic [3:0]   S_AXI_AWADDR;
  logic [2:0]   S_AXI_AWPROT;
  logic         S_AXI_AWVALID;
  logic         S_AXI_AWREADY;
  logic [31:0]  S_AXI_WDATA;
  logic [3:0]   S_AXI_WSTRB;
  logic         S_AXI_WVALID;
  logic         S_AXI_WREADY;
  logic [1:0]   S_AXI_BRESP;
  logic         S_AXI_BVALID;
  logic         S_AXI_BREADY;
  logic [3:0]   S_AXI_ARADDR;
  logic [2:0]   S_AXI_ARPROT;
  logic         S_AXI_ARVALID;
  logic         S_AXI_ARREADY;
  logic [31:0]  S_AXI_RDATA;
  logic [1:0]   S_AXI_RRESP;
  logic         S_AXI_RVALID;
  logic         S_AXI_RREADY;
  logic [127:0] ctrl_regs;
  logic [3:0]   reg_wr_pulse;

  int tests = 0;
  int fails = 0;
  logic [1:0]  bq[$];
  logic [31:0] rq[$];
  logic [31:0] r_prev;
  logic        r_hold = 1'b0;

  always #5 tb_ACLK = ~tb_ACLK;

  axi_lite_audio_regs #(
    .C_S_AXI_DATA_WIDTH(32),
    .C_S_AXI_ADDR_WIDTH(4),
    .RESET_VAL(32'h0000_0000)
  ) dut (
    .ACLK(tb_ACLK), .ARESETN(ARESETN),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
    .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
    .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
    .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
    .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
    .ctrl_regs(ctrl_regs), .reg_wr_pulse(reg_wr_pulse)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    tests++;
    fails++;
    $display("FAIL %s: timeout waiting for handshake", name);
  endtask

  task automatic tick;
    @(posedge tb_ACLK);
    #1;
  endtask

  // Monitor: compare each B/R handshake against the scoreboard, and watch RDATA stability.
  always @(negedge tb_ACLK) begin
    if (!ARESETN) begin
      r_hold = 1'b0;
    end else begin
      if (S_AXI_BVALID && S_AXI_BREADY) begin
        if (bq.size() == 0) chk("unexpected_bresp", 1'b1, 1'b0);
        else chk("bresp", S_AXI_BRESP, bq.pop_front());
      end
      if (S_AXI_RVALID && r_hold) chk("rdata_stable", S_AXI_RDATA, r_prev);
      if (S_AXI_RVALID && S_AXI_RREADY) begin
        if (rq.size() == 0) chk("unexpected_rdata", 1'b1, 1'b0);
        else chk("rdata", S_AXI_RDATA, rq.pop_front());
        chk("rresp", S_AXI_RRESP, 2'b00);
      end
      r_hold = S_AXI_RVALID && !S_AXI_RREADY;
      r_prev = S_AXI_RDATA;
    end
  end

  task automatic issue_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb);
    int n;
    logic aw_acc, w_acc;
    S_AXI_AWADDR = addr; S_AXI_WDATA = data; S_AXI_WSTRB = strb;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
    n = 0;
    while ((S_AXI_AWVALID || S_AXI_WVALID) && n < 50) begin
      aw_acc = S_AXI_AWVALID && S_AXI_AWREADY;
      w_acc  = S_AXI_WVALID && S_AXI_WREADY;
      tick();
      if (aw_acc) S_AXI_AWVALID = 1'b0;
      if (w_acc)  S_AXI_WVALID  = 1'b0;
      n++;
    end
    if (S_AXI_AWVALID || S_AXI_WVALID) begin
      timeout("aw_w_accept");
      S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    end
  endtask

  task automatic wait_b;
    int n = 0;
    while (!(S_AXI_BVALID && S_AXI_BREADY) && n < 50) begin tick(); n++; end
    if (!(S_AXI_BVALID && S_AXI_BREADY)) timeout("bresp");
    else tick();
  endtask

  task automatic write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb);
    bq.push_back(2'b00);
    issue_write(addr, data, strb);
    wait_b();
  endtask

  task automatic issue_ar(input logic [3:0] addr);
    int n = 0;
    logic acc;
    S_AXI_ARADDR = addr; S_AXI_ARVALID = 1'b1;
    while (S_AXI_ARVALID && n < 50) begin
      acc = S_AXI_ARREADY;
      tick();
      if (acc) S_AXI_ARVALID = 1'b0;
      n++;
    end
    if (S_AXI_ARVALID) begin timeout("ar_accept"); S_AXI_ARVALID = 1'b0; end
  endtask

  task automatic wait_r;
    int n = 0;
    while (!(S_AXI_RVALID && S_AXI_RREADY) && n < 50) begin tick(); n++; end
    if (!(S_AXI_RVALID && S_AXI_RREADY)) timeout("rdata");
    else tick();
  endtask

  task automatic read(input logic [3:0] addr, input logic [31:0] exp);
    rq.push_back(exp);
    issue_ar(addr);
    wait_r();
  endtask

  initial begin
    ARESETN = 1'b0;
    S_AXI_AWADDR = '0; S_AXI_AWPROT = '0; S_AXI_AWVALID = 1'b0;
    S_AXI_WDATA = '0; S_AXI_WSTRB = '0; S_AXI_WVALID = 1'b0;
    S_AXI_BREADY = 1'b1;
    S_AXI_ARADDR = '0; S_AXI_ARPROT = '0; S_AXI_ARVALID = 1'b0;
    S_AXI_RREADY = 1'b1;
    tick(); tick();

    // Reset state
    chk("rst_awready", S_AXI_AWREADY, 1'b0);
    chk("rst_wready", S_AXI_WREADY, 1'b0);
    chk("rst_arready", S_AXI_ARREADY, 1'b0);
    chk("rst_bvalid", S_AXI_BVALID, 1'b0);
    chk("rst_rvalid", S_AXI_RVALID, 1'b0);
    chk("rst_rdata", S_AXI_RDATA, 32'h0);
    chk("rst_regs", ctrl_regs, 128'h0);
    chk("rst_pulse", reg_wr_pulse, 4'h0);
    ARESETN = 1'b1;
    tick();
    chk("post_rst_ready", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 3'b111);

    // Basic write/readback on all four registers
    write(4'h0, 32'h0101_FFFF, 4'hF); read(4'h0, 32'h0101_FFFF);
    write(4'h4, 32'hABCD_0001, 4'hF); read(4'h4, 32'hABCD_0001);
    write(4'h8, 32'hDEAD_0011, 4'hF); read(4'h8, 32'hDEAD_0011);
    write(4'hC, 32'hBEEF_0011, 4'hF); read(4'hC, 32'hBEEF_0011);
    chk("ctrl_regs_all", ctrl_regs, 128'hBEEF0011_DEAD0011_ABCD0001_0101FFFF);

    // AW first, W three cycles later
    bq.push_back(2'b00);
    S_AXI_AWADDR = 4'h4; S_AXI_AWVALID = 1'b1;
    S_AXI_WDATA = 32'h0000_0055; S_AXI_WSTRB = 4'hF;
    chk("aw_first_awready", S_AXI_AWREADY, 1'b1);
    tick(); S_AXI_AWVALID = 1'b0;
    tick(); tick();
    S_AXI_WVALID = 1'b1;
    chk("aw_held_state", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, reg_wr_pulse}, {3'b010, 4'h0});
    tick(); S_AXI_WVALID = 1'b0;
    chk("aw_first_commit", {S_AXI_BVALID, reg_wr_pulse}, {1'b1, 4'b0010});
    chk("aw_first_reg1", ctrl_regs[63:32], 32'h0000_0055);
    tick();
    chk("aw_first_pulse_end", {S_AXI_BVALID, reg_wr_pulse}, {1'b0, 4'b0000});

    // W first, AW three cycles later
    bq.push_back(2'b00);
    S_AXI_WDATA = 32'h0000_0066; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
    S_AXI_AWADDR = 4'h4;
    tick(); S_AXI_WVALID = 1'b0;
    tick(); tick();
    S_AXI_AWVALID = 1'b1;
    chk("w_held_state", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, reg_wr_pulse}, {3'b100, 4'h0});
    tick(); S_AXI_AWVALID = 1'b0;
    chk("w_first_commit", {S_AXI_BVALID, reg_wr_pulse}, {1'b1, 4'b0010});
    chk("w_first_reg1", ctrl_regs[63:32], 32'h0000_0066);
    tick();
    chk("w_first_pulse_end", reg_wr_pulse, 4'b0000);

    // Byte strobes
    write(4'h0, 32'hFFFF_FFFF, 4'hF);
    write(4'h0, 32'h1234_5678, 4'b0101);
    read(4'h0, 32'hFF34_FF78);
    write(4'h0, 32'h0000_0000, 4'b0000);
    read(4'h0, 32'hFF34_FF78);

    // Backpressure on B: second write must wait
    S_AXI_BREADY = 1'b0;
    bq.push_back(2'b00);
    issue_write(4'hC, 32'h0000_0C0C, 4'hF);
    S_AXI_AWADDR = 4'h8; S_AXI_WDATA = 32'h0000_0808; S_AXI_WSTRB = 4'hF;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("b_stall", {S_AXI_BVALID, S_AXI_AWREADY, S_AXI_WREADY}, 3'b100);
      tick();
    end
    chk("b_stall_reg2", ctrl_regs[95:64], 32'hDEAD_0011);
    S_AXI_BREADY = 1'b1;
    wait_b();
    bq.push_back(2'b00);
    issue_write(4'h8, 32'h0000_0808, 4'hF);
    wait_b();
    read(4'h8, 32'h0000_0808);
    read(4'hC, 32'h0000_0C0C);

    // Backpressure on R: RDATA held
    S_AXI_RREADY = 1'b0;
    rq.push_back(32'hFF34_FF78);
    issue_ar(4'h0);
    for (int i = 0; i < 4; i++) begin
      chk("r_stall", {S_AXI_RVALID, S_AXI_ARREADY, S_AXI_RDATA}, {2'b10, 32'hFF34_FF78});
      tick();
    end
    S_AXI_RREADY = 1'b1;
    wait_r();

    // Read and write commit to the same register on one edge
    write(4'h8, 32'h1111_1111, 4'hF);
    bq.push_back(2'b00);
    rq.push_back(32'h1111_1111);
    S_AXI_AWADDR = 4'h8; S_AXI_WDATA = 32'h2222_2222; S_AXI_WSTRB = 4'hF;
    S_AXI_ARADDR = 4'h8;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1; S_AXI_ARVALID = 1'b1;
    tick();
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_ARVALID = 1'b0;
    chk("same_edge_valids", {S_AXI_BVALID, S_AXI_RVALID}, 2'b11);
    tick(); tick();
    read(4'h8, 32'h2222_2222);

    // Reset with B and R pending
    S_AXI_BREADY = 1'b0; S_AXI_RREADY = 1'b0;
    issue_write(4'h0, 32'hAAAA_5555, 4'hF);
    issue_ar(4'h4);
    chk("pre_rst_pending", {S_AXI_BVALID, S_AXI_RVALID}, 2'b11);
    ARESETN = 1'b0;
    #1;
    chk("mid_rst_regs", ctrl_regs, 128'h0);
    chk("mid_rst_valids", {S_AXI_BVALID, S_AXI_RVALID, S_AXI_RDATA}, 34'h0);
    tick();
    ARESETN = 1'b1; S_AXI_BREADY = 1'b1; S_AXI_RREADY = 1'b1;
    tick();

    // Reset with AW held: the held address must be dropped
    S_AXI_AWADDR = 4'h4; S_AXI_AWVALID = 1'b1;
    tick(); S_AXI_AWVALID = 1'b0;
    ARESETN = 1'b0;
    tick();
    ARESETN = 1'b1;
    tick();
    write(4'hC, 32'h0000_003C, 4'hF);
    chk("post_rst_write", ctrl_regs, {32'h0000_003C, 96'h0});
    read(4'h4, 32'h0000_0000);

    tick(); tick();
    chk("bq_drained", bq.size(), 0);
    chk("rq_drained", rq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
